// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
//   DEF_WIDTH   - default divisor/counter width
//   DEF_DIV     - default divisor active after reset
//   high_len()  - number of high cycles in a period of divisor d, (d+1)/2
package clk_div_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DIV   = 4;

    // (d+1)/2 written as d/2 + lsb so an all-ones divisor cannot overflow
    function automatic logic [31:0] high_len(input logic [31:0] d);
        return (d >> 1) + {31'd0, d[0]};
    endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Divisor shadow register: accepts/rejects divisor loads, holds the pending
// value and hands it to the counter at the wrap edge.
//   clk, rst   - clock, synchronous active-high reset
//   div_in     - requested divisor
//   div_load   - one-cycle load strobe
//   wrap       - counter is at its wrap edge this cycle (already qualified by en)
//   apply      - a new divisor takes effect on this edge (combinational)
//   apply_div  - the divisor to take effect when apply is high
//   div_ack    - registered pulse, a new divisor became active
//   div_err    - registered pulse, a zero divisor load was rejected
module div_shadow #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    input  logic             wrap,
    output logic             apply,
    output logic [WIDTH-1:0] apply_div,
    output logic             div_ack,
    output logic             div_err
);

    logic             pending;
    logic [WIDTH-1:0] pend_div;
    logic             load_ok;
    logic             load_bad;

    always_comb begin
        load_ok  = div_load && (div_in != '0);
        load_bad = div_load && (div_in == '0);
        // A load on the wrap edge itself supersedes any older pending value
        apply     = wrap && (load_ok || pending);
        apply_div = load_ok ? div_in : pend_div;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b0;
            pend_div <= '0;
            div_ack  <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            div_err <= load_bad;
            div_ack <= apply;
            if (apply) begin
                pending <= 1'b0;
            end else if (load_ok) begin
                pending  <= 1'b1;
                pend_div <= div_in;
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free divisor updates at period
// boundaries. clk_out is a registered level, not a generated clock.
//   clk, rst  - clock, synchronous active-high reset
//   en        - count enable; the divider freezes while low
//   div_in    - requested divisor (0 is rejected)
//   div_load  - one-cycle load strobe for div_in
//   div_ack   - pulse: new divisor became active
//   div_err   - pulse: load rejected
//   tick      - pulse once per divided period
//   clk_out   - divided level, high for ceil(D/2) cycles then low floor(D/2)
//   cnt       - phase counter, 0..D-1
//   div_cur   - divisor currently active
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             tick,
    output logic             clk_out,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] div_cur
);

    localparam longint unsigned MAX_DIV = (64'd1 << WIDTH) - 64'd1;

    if (WIDTH < 1 || WIDTH > 31 || DEFAULT_DIV < 1 || 64'(DEFAULT_DIV) > MAX_DIV) begin : g_bad_param
        $error("clk_div_prog: DEFAULT_DIV must be 1..2^WIDTH-1 and WIDTH 1..31");
    end

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

    logic             wrap;
    logic             apply;
    logic [WIDTH-1:0] apply_div;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] div_next;

    always_comb begin
        // div_cur is never 0, so div_cur-1 cannot underflow
        wrap     = en && (cnt == div_cur - WIDTH'(1));
        cnt_next = wrap ? '0 : cnt + WIDTH'(1);
        div_next = apply ? apply_div : div_cur;
    end

    div_shadow #(.WIDTH(WIDTH)) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .div_in    (div_in),
        .div_load  (div_load),
        .wrap      (wrap),
        .apply     (apply),
        .apply_div (apply_div),
        .div_ack   (div_ack),
        .div_err   (div_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            div_cur <= RESET_DIV;
            tick    <= 1'b0;
            clk_out <= 1'b1;
        end else if (en) begin
            cnt     <= cnt_next;
            div_cur <= div_next;
            tick    <= wrap;
            // Compare against the divisor governing the next cycle so a
            // freshly applied divisor shapes clk_out from its first cycle
            clk_out <= (32'(cnt_next) < high_len(32'(div_next)));
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic       a_rst, a_en, a_load;
    logic [7:0] a_din;
    logic       a_ack, a_err, a_tick, a_co;
    logic [7:0] a_cnt, a_cur;

    clk_div_prog u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .div_in(a_din), .div_load(a_load),
        .div_ack(a_ack), .div_err(a_err), .tick(a_tick), .clk_out(a_co),
        .cnt(a_cnt), .div_cur(a_cur)
    );

    // DUT B: narrow instance for the all-ones divisor and reset cases
    logic       b_rst, b_en, b_load;
    logic [3:0] b_din;
    logic       b_ack, b_err, b_tick, b_co;
    logic [3:0] b_cnt, b_cur;

    clk_div_prog #(.WIDTH(4), .DEFAULT_DIV(4)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .div_in(b_din), .div_load(b_load),
        .div_ack(b_ack), .div_err(b_err), .tick(b_tick), .clk_out(b_co),
        .cnt(b_cnt), .div_cur(b_cur)
    );

    typedef struct {
        logic       sel;
        int         idx;
        logic [7:0] cnt;
        logic [7:0] cur;
        logic       co, tick, ack, err;
    } exp_t;

    typedef struct {
        logic       rst, en, load;
        logic [7:0] din;
        logic [7:0] cnt, cur;
        logic       co, tick, ack, err;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   seq    = 0;

    function automatic void add(input logic r, e, l, input logic [7:0] d,
                                input logic [7:0] c, cu, input logic o, t, a, er);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.din = d;
        v.cnt = c; v.cur = cu; v.co = o; v.tick = t; v.ack = a; v.err = er;
        tbl.push_back(v);
    endfunction

    function automatic exp_t mk(input logic s, input logic [7:0] c, cu,
                                input logic o, t, a, er);
        exp_t x;
        x.sel = s; x.idx = 0; x.cnt = c; x.cur = cu;
        x.co = o; x.tick = t; x.ack = a; x.err = er;
        return x;
    endfunction

    task automatic step_a(input logic r, e, l, input logic [7:0] d, input exp_t x);
        @(negedge clk);
        a_rst = r; a_en = e; a_load = l; a_din = d;
        b_rst = 1'b1; b_en = 1'b0; b_load = 1'b0; b_din = '0;
        x.sel = 1'b0; x.idx = seq; seq++;
        sb.push_back(x);
    endtask

    task automatic step_b(input logic r, e, l, input logic [3:0] d, input exp_t x);
        @(negedge clk);
        b_rst = r; b_en = e; b_load = l; b_din = d;
        a_rst = 1'b1; a_en = 1'b0; a_load = 1'b0; a_din = '0;
        x.sel = 1'b1; x.idx = seq; seq++;
        sb.push_back(x);
    endtask

    // Scoreboard: one expectation consumed per clock, sampled after the edge
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t       x;
            logic [19:0] act, req;
            x = sb.pop_front();
            if (x.sel == 1'b0)
                act = {a_cnt, a_cur, a_co, a_tick, a_ack, a_err};
            else
                act = {4'd0, b_cnt, 4'd0, b_cur, b_co, b_tick, b_ack, b_err};
            req = {x.cnt, x.cur, x.co, x.tick, x.ack, x.err};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL step%0d dut=%s: got cnt=%0d cur=%0d clk_out=%b tick=%b ack=%b err=%b, want cnt=%0d cur=%0d clk_out=%b tick=%b ack=%b err=%b",
                         x.idx, x.sel ? "B" : "A",
                         act[19:12], act[11:4], act[3], act[2], act[1], act[0],
                         x.cnt, x.cur, x.co, x.tick, x.ack, x.err);
            end
        end
    end

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_load = 1'b0; a_din = '0;
        b_rst = 1'b1; b_en = 1'b0; b_load = 1'b0; b_din = '0;

        //   rst en ld din   cnt cur co t  a  e
        add(1, 0, 0, 0,     0, 4, 1, 0, 0, 0);   // reset state
        add(0, 1, 0, 0,     1, 4, 1, 0, 0, 0);   // default D=4
        add(0, 1, 0, 0,     2, 4, 0, 0, 0, 0);
        add(0, 1, 0, 0,     3, 4, 0, 0, 0, 0);
        add(0, 1, 0, 0,     0, 4, 1, 1, 0, 0);
        add(0, 1, 0, 0,     1, 4, 1, 0, 0, 0);
        add(0, 1, 0, 0,     2, 4, 0, 0, 0, 0);
        add(0, 1, 0, 0,     3, 4, 0, 0, 0, 0);
        add(0, 1, 0, 0,     0, 4, 1, 1, 0, 0);
        add(0, 1, 0, 0,     1, 4, 1, 0, 0, 0);
        add(0, 1, 1, 5,     2, 4, 0, 0, 0, 0);   // load 5 at cnt=1
        add(0, 1, 0, 0,     3, 4, 0, 0, 0, 0);
        add(0, 1, 0, 0,     0, 5, 1, 1, 1, 0);   // applied at wrap, ack
        add(0, 1, 0, 0,     1, 5, 1, 0, 0, 0);
        add(0, 1, 0, 0,     2, 5, 1, 0, 0, 0);
        add(0, 1, 0, 0,     3, 5, 0, 0, 0, 0);
        add(0, 1, 0, 0,     4, 5, 0, 0, 0, 0);
        add(0, 1, 0, 0,     0, 5, 1, 1, 0, 0);
        add(0, 1, 1, 7,     1, 5, 1, 0, 0, 0);   // load 7
        add(0, 1, 1, 3,     2, 5, 1, 0, 0, 0);   // load 3, last wins
        add(0, 1, 0, 0,     3, 5, 0, 0, 0, 0);
        add(0, 1, 0, 0,     4, 5, 0, 0, 0, 0);
        add(0, 1, 0, 0,     0, 3, 1, 1, 1, 0);
        add(0, 1, 0, 0,     1, 3, 1, 0, 0, 0);
        add(0, 1, 0, 0,     2, 3, 0, 0, 0, 0);
        add(0, 1, 0, 0,     0, 3, 1, 1, 0, 0);   // single ack only
        add(0, 1, 1, 0,     1, 3, 1, 0, 0, 1);   // zero load rejected
        add(0, 1, 0, 0,     2, 3, 0, 0, 0, 0);
        add(0, 1, 0, 0,     0, 3, 1, 1, 0, 0);   // period unchanged
        add(0, 1, 1, 2,     1, 3, 1, 0, 0, 0);   // pending 2
        add(0, 1, 1, 0,     2, 3, 0, 0, 0, 1);   // reject keeps pending
        add(0, 1, 0, 0,     0, 2, 1, 1, 1, 0);
        add(0, 1, 0, 0,     1, 2, 0, 0, 0, 0);
        add(0, 1, 0, 0,     0, 2, 1, 1, 0, 0);
        add(0, 1, 1, 1,     1, 2, 0, 0, 0, 0);   // load D=1
        add(0, 1, 0, 0,     0, 1, 1, 1, 1, 0);
        add(0, 1, 0, 0,     0, 1, 1, 1, 0, 0);
        add(0, 1, 0, 0,     0, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0,     0, 1, 1, 0, 0, 0);   // en=0: no tick
        add(0, 1, 1, 4,     0, 4, 1, 1, 1, 0);   // load on wrap edge
        add(0, 1, 0, 0,     1, 4, 1, 0, 0, 0);
        add(0, 1, 0, 0,     2, 4, 0, 0, 0, 0);
        add(0, 0, 1, 6,     2, 4, 0, 0, 0, 0);   // freeze, load accepted
        add(0, 0, 0, 0,     2, 4, 0, 0, 0, 0);
        add(0, 0, 0, 0,     2, 4, 0, 0, 0, 0);
        add(0, 1, 0, 0,     3, 4, 0, 0, 0, 0);   // resumes from 2
        add(0, 1, 0, 0,     0, 6, 1, 1, 1, 0);
        add(0, 1, 0, 0,     1, 6, 1, 0, 0, 0);
        add(0, 1, 1, 9,     2, 6, 1, 0, 0, 0);   // pending 9
        add(1, 1, 1, 8,     0, 4, 1, 0, 0, 0);   // rst dominates
        add(0, 1, 0, 0,     1, 4, 1, 0, 0, 0);
        add(0, 1, 0, 0,     2, 4, 0, 0, 0, 0);
        add(0, 1, 0, 0,     3, 4, 0, 0, 0, 0);
        add(0, 1, 0, 0,     0, 4, 1, 1, 0, 0);   // pending discarded
        add(1, 1, 1, 0,     0, 4, 1, 0, 0, 0);   // rst masks zero load
        add(0, 1, 0, 0,     1, 4, 1, 0, 0, 0);

        foreach (tbl[i]) begin
            step_a(tbl[i].rst, tbl[i].en, tbl[i].load, tbl[i].din,
                   mk(1'b0, tbl[i].cnt, tbl[i].cur, tbl[i].co, tbl[i].tick, tbl[i].ack, tbl[i].err));
        end

        // A: all-ones divisor on the 8-bit instance
        step_a(0, 1, 1, 8'd255, mk(0, 2, 4, 0, 0, 0, 0));
        step_a(0, 1, 0, 8'd0,   mk(0, 3, 4, 0, 0, 0, 0));
        step_a(0, 1, 0, 8'd0,   mk(0, 0, 255, 1, 1, 1, 0));
        for (int i = 1; i <= 520; i++) begin
            logic [7:0] c;
            c = 8'(i % 255);
            step_a(0, 1, 0, 8'd0, mk(0, c, 255, (c < 8'd128), (c == 8'd0), 0, 0));
        end

        // B: WIDTH=4, D=15, reset at cnt=9 with a load pending
        step_b(1, 0, 0, 4'd0,  mk(1, 0, 4, 1, 0, 0, 0));
        step_b(0, 1, 1, 4'd15, mk(1, 1, 4, 1, 0, 0, 0));
        step_b(0, 1, 0, 4'd0,  mk(1, 2, 4, 0, 0, 0, 0));
        step_b(0, 1, 0, 4'd0,  mk(1, 3, 4, 0, 0, 0, 0));
        step_b(0, 1, 0, 4'd0,  mk(1, 0, 15, 1, 1, 1, 0));
        for (int i = 1; i <= 23; i++) begin
            logic [7:0] c;
            c = 8'(i % 15);
            step_b(0, 1, 0, 4'd0, mk(1, c, 15, (c < 8'd8), (c == 8'd0), 0, 0));
        end
        step_b(0, 1, 1, 4'd5, mk(1, 9, 15, 0, 0, 0, 0));
        step_b(1, 1, 0, 4'd0, mk(1, 0, 4, 1, 0, 0, 0));
        step_b(0, 1, 0, 4'd0, mk(1, 1, 4, 1, 0, 0, 0));
        step_b(0, 1, 0, 4'd0, mk(1, 2, 4, 0, 0, 0, 0));
        step_b(0, 1, 0, 4'd0, mk(1, 3, 4, 0, 0, 0, 0));
        step_b(0, 1, 0, 4'd0, mk(1, 0, 4, 1, 1, 0, 0));

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d expectations left, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
